// File: rtl/operand_bypass.sv
// Operand bypass: per-register in-flight writer scoreboard, EX/MEM/WB
// forward selection for the two decode sources, hazard stall generation
// and the registered ID/EX operand boundary.
//
// Handshake: decode offers an instruction with id_valid; it is taken
// (issue) in a cycle where id_valid=1, stall_req=0, stall=0 and flush=0.
// op_valid marks that op1/op2 hold the operands of an instruction
// issued on the previous accepted edge.
module operand_bypass #(
  parameter int NREG = 32,
  parameter int XLEN = 64,
  parameter int CNTW = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_regwrite,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            fwd_ex_valid,
  input  logic [AW-1:0]   fwd_ex_dst,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_mem_valid,
  input  logic [AW-1:0]   fwd_mem_dst,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [AW-1:0]   fwd_wb_dst,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            commit_valid,
  input  logic [AW-1:0]   commit_dst,
  output logic            stall_req,
  output logic            op_valid,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [15:0]     hazard_cycles,
  output logic            dbg_wait
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [NREG-1:0] inc_vec, dec_vec;
  logic            op_valid_q, op_valid_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [15:0]     hz_q, hz_d;
  logic [XLEN:0]   res1, res2;
  logic            rdy1, rdy2, rd_full, issue;

  // Returns {hit, data}: youngest forward entry wins, then the register file.
  function automatic logic [XLEN:0] resolve(
    input logic [AW-1:0]   s,
    input logic [XLEN-1:0] rf,
    input logic            exv,
    input logic [AW-1:0]   exd,
    input logic [XLEN-1:0] exx,
    input logic            mmv,
    input logic [AW-1:0]   mmd,
    input logic [XLEN-1:0] mmx,
    input logic            wbv,
    input logic [AW-1:0]   wbd,
    input logic [XLEN-1:0] wbx
  );
    logic [XLEN:0] r;
    if (s == '0)                  r = {1'b0, {XLEN{1'b0}}};
    else if (exv && exd == s)     r = {1'b1, exx};
    else if (mmv && mmd == s)     r = {1'b1, mmx};
    else if (wbv && wbd == s)     r = {1'b1, wbx};
    else                          r = {1'b0, rf};
    return r;
  endfunction

  // Source resolution, readiness and the combinational hazard stall.
  always_comb begin
    res1 = resolve(id_rs1, rf_rdata1, fwd_ex_valid, fwd_ex_dst, fwd_ex_data,
                   fwd_mem_valid, fwd_mem_dst, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_dst, fwd_wb_data);
    res2 = resolve(id_rs2, rf_rdata2, fwd_ex_valid, fwd_ex_dst, fwd_ex_data,
                   fwd_mem_valid, fwd_mem_dst, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_dst, fwd_wb_data);
    rdy1      = (id_rs1 == '0) || (cnt_q[id_rs1] == '0) || res1[XLEN];
    rdy2      = (id_rs2 == '0) || (cnt_q[id_rs2] == '0) || res2[XLEN];
    rd_full   = id_regwrite && (id_rd != '0) && (cnt_q[id_rd] == CNT_MAX);
    stall_req = id_valid && (!rdy1 || !rdy2 || rd_full);
    issue     = id_valid && !stall_req && !stall && !flush;
  end

  // Per-register increment (issue) and decrement (commit) requests.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && id_regwrite && id_rd != '0) inc_vec[id_rd] = 1'b1;
    if (commit_valid && !stall && commit_dst != '0 && cnt_q[commit_dst] != '0)
      dec_vec[commit_dst] = 1'b1;
  end

  // Scoreboard next state; flush wipes every pending writer.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush)                          cnt_d[r] = '0;
      else if (inc_vec[r] && !dec_vec[r]) cnt_d[r] = cnt_q[r] + CNTW'(1);
      else if (dec_vec[r] && !inc_vec[r]) cnt_d[r] = cnt_q[r] - CNTW'(1);
    end
  end

  // FSM next state: mirrors stall_req on unstalled cycles.
  always_comb begin
    state_d = state_q;
    if (flush)       state_d = RUN;
    else if (!stall) state_d = stall_req ? WAIT : RUN;
  end

  // ID/EX operand register and hazard counter next state.
  always_comb begin
    op_valid_d = op_valid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    if (flush) begin
      op_valid_d = 1'b0;
    end else if (!stall) begin
      op_valid_d = issue;
      if (issue) begin
        op1_d = res1[XLEN-1:0];
        op2_d = res2[XLEN-1:0];
      end
    end
    hz_d = (stall_req && hz_q != 16'hFFFF) ? hz_q + 16'd1 : hz_q;
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      op_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      hz_q       <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      op_valid_q <= op_valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      hz_q       <= hz_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign op_valid      = op_valid_q;
  assign op1           = op1_q;
  assign op2           = op2_q;
  assign hazard_cycles = hz_q;
  assign dbg_wait      = (state_q == WAIT);

endmodule

// File: tb/tb_operand_bypass.sv
// Testbench for operand_bypass: vector table with a scoreboard queue of
// expected operands, plus hand-written reset sequences.
module tb_operand_bypass;

  localparam int EX = 0, MEM = 1, WB = 2;

  typedef struct packed {
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rw;
    logic [63:0] rf1, rf2;
    logic        ex_v;  logic [4:0] ex_d;  logic [63:0] ex_x;
    logic        mem_v; logic [4:0] mem_d; logic [63:0] mem_x;
    logic        wb_v;  logic [4:0] wb_d;  logic [63:0] wb_x;
    logic        cm_v;  logic [4:0] cm_d;
    logic        flush, stall;
    logic        exp_stall;
    logic [63:0] exp1, exp2;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        stall, flush, id_valid, id_regwrite;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic        fwd_ex_valid, fwd_mem_valid, fwd_wb_valid, commit_valid;
  logic [4:0]  fwd_ex_dst, fwd_mem_dst, fwd_wb_dst, commit_dst;
  logic [63:0] fwd_ex_data, fwd_mem_data, fwd_wb_data;
  logic        stall_req, op_valid, dbg_wait;
  logic [63:0] op1, op2;
  logic [15:0] hazard_cycles;

  operand_bypass dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_dst(fwd_ex_dst), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_dst(fwd_mem_dst), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_dst(fwd_wb_dst), .fwd_wb_data(fwd_wb_data),
    .commit_valid(commit_valid), .commit_dst(commit_dst),
    .stall_req(stall_req), .op_valid(op_valid), .op1(op1), .op2(op2),
    .hazard_cycles(hazard_cycles), .dbg_wait(dbg_wait)
  );

  // scoreboard state
  logic [127:0] exp_q[$];
  vec_t         tbl[$];
  int           n_chk = 0, n_pass = 0, step = 0;
  logic         exp_opv = 1'b0, exp_st = 1'b0;
  logic [63:0]  last1 = '0, last2 = '0;
  logic [15:0]  exp_hz = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // vector builders
  function automatic vec_t inst(input logic [4:0] rs1, rs2, rd, input logic rw,
                                input logic [63:0] a, b);
    vec_t v = '0;
    v.id_valid = 1'b1; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw;
    v.rf1 = a; v.rf2 = b;
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v = '0;
    return v;
  endfunction

  function automatic vec_t fw(input vec_t v, input int which, input logic [4:0] d,
                              input logic [63:0] x);
    case (which)
      EX:      begin v.ex_v  = 1'b1; v.ex_d  = d; v.ex_x  = x; end
      MEM:     begin v.mem_v = 1'b1; v.mem_d = d; v.mem_x = x; end
      default: begin v.wb_v  = 1'b1; v.wb_d  = d; v.wb_x  = x; end
    endcase
    return v;
  endfunction

  function automatic vec_t cm(input vec_t v, input logic [4:0] d);
    v.cm_v = 1'b1; v.cm_d = d;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t v);
    v.flush = 1'b1;
    return v;
  endfunction

  function automatic vec_t st(input vec_t v);
    v.stall = 1'b1;
    return v;
  endfunction

  function automatic vec_t xp(input vec_t v, input logic s, input logic [63:0] e1, e2);
    v.exp_stall = s; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    id_valid = v.id_valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_regwrite = v.rw; rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
    fwd_ex_valid = v.ex_v;   fwd_ex_dst = v.ex_d;   fwd_ex_data = v.ex_x;
    fwd_mem_valid = v.mem_v; fwd_mem_dst = v.mem_d; fwd_mem_data = v.mem_x;
    fwd_wb_valid = v.wb_v;   fwd_wb_dst = v.wb_d;   fwd_wb_data = v.wb_x;
    commit_valid = v.cm_v;   commit_dst = v.cm_d;
    flush = v.flush; stall = v.stall;
  endtask

  // one cycle: drive, check combinational stall, then registered outputs
  task automatic apply(input vec_t v);
    logic         exp_issue;
    logic [127:0] e;
    drive(v);
    @(negedge clk);
    chk($sformatf("stall_req[%0d]", step), 64'(stall_req), 64'(v.exp_stall));
    exp_issue = v.id_valid && !v.exp_stall && !v.stall && !v.flush;
    if (exp_issue) exp_q.push_back({v.exp1, v.exp2});
    if (v.exp_stall && exp_hz != 16'hFFFF) exp_hz = exp_hz + 16'd1;
    if (v.flush) begin
      exp_opv = 1'b0; exp_st = 1'b0;
    end else if (!v.stall) begin
      exp_opv = exp_issue; exp_st = v.exp_stall;
    end
    @(posedge clk); #1;
    if (exp_issue && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last1 = e[127:64]; last2 = e[63:0];
    end
    chk($sformatf("op_valid[%0d]", step), 64'(op_valid), 64'(exp_opv));
    chk($sformatf("op1[%0d]", step), op1, last1);
    chk($sformatf("op2[%0d]", step), op2, last2);
    chk($sformatf("fsm_wait[%0d]", step), 64'(dbg_wait), 64'(exp_st));
    step++;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
    chk($sformatf("hazard_cycles@%0d", step), 64'(hazard_cycles), 64'(exp_hz));
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_opv = 1'b0; exp_st = 1'b0; last1 = '0; last2 = '0; exp_hz = '0;
  endtask

  logic [63:0] r1, r2;

  initial begin
    // reset with junk on every input
    reset = 1'b0;
    id_valid = 1'b1; id_regwrite = 1'b1; stall = 1'b0; flush = 1'b0;
    id_rs1 = 5'($urandom_range(1, 31)); id_rs2 = 5'($urandom_range(1, 31));
    id_rd = 5'($urandom_range(1, 31));
    rf_rdata1 = {$urandom, $urandom}; rf_rdata2 = {$urandom, $urandom};
    fwd_ex_valid = 1'b1; fwd_ex_dst = id_rs1; fwd_ex_data = {$urandom, $urandom};
    fwd_mem_valid = 1'b1; fwd_mem_dst = id_rs2; fwd_mem_data = {$urandom, $urandom};
    fwd_wb_valid = 1'b1; fwd_wb_dst = id_rd; fwd_wb_data = {$urandom, $urandom};
    commit_valid = 1'b1; commit_dst = id_rd;
    #23;
    chk("reset op_valid", 64'(op_valid), 64'd0);
    chk("reset op1", op1, 64'd0);
    chk("reset op2", op2, 64'd0);
    chk("reset hazard_cycles", 64'(hazard_cycles), 64'd0);
    chk("reset fsm_wait", 64'(dbg_wait), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(idle());
    #1;
    chk("idle stall_req", 64'(stall_req), 64'd0);
    @(posedge clk); #1;

    // forwarding priority, x0, bubble and stall hold
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    tbl.push_back(xp(fw(fw(fw(inst(5, 6, 0, 0, 64'hAAA, 64'h66), EX, 5, 64'h11),
                            MEM, 5, 64'h22), WB, 5, 64'h33), 0, 64'h11, 64'h66));
    tbl.push_back(xp(fw(fw(inst(5, 6, 0, 0, 64'hAAA, 64'h66), MEM, 5, 64'h22),
                         WB, 5, 64'h33), 0, 64'h22, 64'h66));
    tbl.push_back(xp(fw(inst(5, 6, 0, 0, 64'hAAA, 64'h66), WB, 5, 64'h33),
                     0, 64'h33, 64'h66));
    tbl.push_back(xp(inst(5, 6, 0, 0, r1, r2), 0, r1, r2));
    tbl.push_back(xp(fw(inst(0, 0, 0, 1, 64'h5, 64'h6), EX, 0, 64'hFF), 0, 64'h0, 64'h0));
    tbl.push_back(xp(fw(fw(fw(inst(10, 11, 0, 0, 64'h1, 64'h2), MEM, 10, 64'h1010),
                            WB, 11, 64'h1111), EX, 12, 64'h1212), 0, 64'h1010, 64'h1111));
    tbl.push_back(xp(fw(fw(inst(10, 11, 0, 0, 64'h1, 64'h2), EX, 11, 64'h77),
                         WB, 11, 64'h1111), 0, 64'h1, 64'h77));
    tbl.push_back(xp(inst(1, 2, 0, 0, 64'h101, 64'h202), 0, 64'h101, 64'h202));
    tbl.push_back(xp(st(inst(1, 2, 0, 0, 64'h999, 64'h888)), 0, 64'h0, 64'h0));
    tbl.push_back(xp(idle(), 0, 64'h0, 64'h0));
    run_tbl();

    // load-use: EX cannot forward a load, MEM resolves it a cycle later
    tbl.push_back(xp(inst(1, 2, 7, 1, 64'h1, 64'h2), 0, 64'h1, 64'h2));
    tbl.push_back(xp(inst(7, 0, 8, 0, 64'hDEAD, 64'h0), 1, 64'h0, 64'h0));
    tbl.push_back(xp(fw(inst(7, 0, 8, 0, 64'hDEAD, 64'h0), MEM, 7, 64'hABCD),
                     0, 64'hABCD, 64'h0));
    tbl.push_back(xp(cm(idle(), 7), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(7, 0, 0, 0, 64'h7777, 64'h0), 0, 64'h7777, 64'h0));
    run_tbl();

    // scoreboard saturation and same-cycle issue/commit
    for (int i = 0; i < 3; i++) tbl.push_back(xp(inst(0, 0, 3, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(0, 0, 3, 1, 64'h0, 64'h0), 1, 64'h0, 64'h0));
    tbl.push_back(xp(cm(inst(0, 0, 3, 1, 64'h0, 64'h0), 3), 1, 64'h0, 64'h0));
    tbl.push_back(xp(inst(0, 0, 3, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(cm(idle(), 3), 0, 64'h0, 64'h0));
    tbl.push_back(xp(cm(inst(0, 0, 3, 1, 64'h0, 64'h0), 3), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(0, 0, 3, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(0, 0, 3, 1, 64'h0, 64'h0), 1, 64'h0, 64'h0));
    for (int i = 0; i < 3; i++) tbl.push_back(xp(cm(idle(), 3), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(3, 0, 0, 0, 64'h33, 64'h0), 0, 64'h33, 64'h0));
    // commit to an idle register must not underflow
    tbl.push_back(xp(cm(idle(), 20), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(0, 0, 20, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(20, 0, 0, 0, 64'h2020, 64'h0), 1, 64'h0, 64'h0));
    tbl.push_back(xp(cm(idle(), 20), 0, 64'h0, 64'h0));
    // a commit under global stall is frozen
    tbl.push_back(xp(inst(0, 0, 13, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(st(cm(idle(), 13)), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(13, 0, 0, 0, 64'h1313, 64'h0), 1, 64'h0, 64'h0));
    tbl.push_back(xp(cm(idle(), 13), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(13, 0, 0, 0, 64'h1313, 64'h0), 0, 64'h1313, 64'h0));
    run_tbl();

    // flush clears pending writers and op_valid, even under stall
    tbl.push_back(xp(inst(0, 0, 9, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(0, 0, 9, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    tbl.push_back(xp(st(fl(idle())), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(9, 0, 0, 0, 64'h909, 64'h0), 0, 64'h909, 64'h0));
    tbl.push_back(xp(fl(inst(1, 2, 4, 1, 64'h1, 64'h2)), 0, 64'h0, 64'h0));
    tbl.push_back(xp(inst(4, 0, 0, 0, 64'h404, 64'h0), 0, 64'h404, 64'h0));
    run_tbl();

    // asynchronous reset in the middle of a hazard stall
    apply(xp(inst(0, 0, 4, 1, 64'h0, 64'h0), 0, 64'h0, 64'h0));
    drive(st(inst(4, 0, 0, 0, 64'h4444, 64'h0)));
    #1;
    chk("pre-reset stall_req", 64'(stall_req), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset op_valid", 64'(op_valid), 64'd0);
    chk("async reset op1", op1, 64'd0);
    chk("async reset hazard_cycles", 64'(hazard_cycles), 64'd0);
    chk("async reset stall_req", 64'(stall_req), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(idle());
    clear_model();
    @(posedge clk); #1;
    tbl.push_back(xp(inst(4, 0, 0, 0, 64'h4444, 64'h0), 0, 64'h4444, 64'h0));
    run_tbl();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
